// File: rtl/instr_fetch_buffer.sv
// Dual-issue instruction fetch stage: PC, credit-managed pair FIFO and registered decode outputs.
// Define FETCH_PERF_EN to add the saturating perf_bubble_cnt / perf_stall_cnt outputs.
module instr_fetch_buffer #(
  parameter int unsigned          DEPTH     = 4,
  parameter int unsigned          LS_ADDR_W = 18,
  parameter logic [LS_ADDR_W-1:0] RESET_PC  = {LS_ADDR_W{1'b0}}
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 redirect_valid,
  input  logic [LS_ADDR_W-1:0] redirect_pc,
  output logic                 imem_req,
  output logic [LS_ADDR_W-1:0] imem_addr,
  input  logic                 imem_rvalid,
  input  logic [0:63]          imem_rdata,
  output logic [0:31]          instruction_in1,
  output logic [0:31]          instruction_in2,
  output logic                 instr_valid,
  output logic [LS_ADDR_W-1:0] fetch_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [0:31]          perf_bubble_cnt,
  output logic [0:31]          perf_stall_cnt
`endif
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [CNT_W:0]         DEPTH_C   = (CNT_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0]       CNT_ONE   = CNT_W'(1'b1);
  localparam logic [PTR_W-1:0]       PTR_ONE   = PTR_W'(1'b1);
  localparam logic [LS_ADDR_W-1:0]   PC_STEP   = LS_ADDR_W'(4'd8);
  localparam logic [LS_ADDR_W-1:0]   DW_MASK   = {{(LS_ADDR_W-3){1'b1}}, 3'b000};
  localparam logic [0:31]            NOP_WORD  = 32'h4020_0000;
  localparam logic [0:31]            LNOP_WORD = 32'h0020_0000;

  // Pair storage: instruction doubleword plus the address it was fetched from.
  logic [0:63]          fifo_data [DEPTH];
  logic [LS_ADDR_W-1:0] fifo_addr [DEPTH];

  logic [LS_ADDR_W-1:0] pc;
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W-1:0]     wr_ptr;
  logic [CNT_W-1:0]     count;
  logic                 outstanding;
  logic [LS_ADDR_W-1:0] pending_addr;

  logic [CNT_W:0]       credit_used;
  logic                 fifo_empty;
  logic                 req;
  logic                 push;
  logic                 pop;

  // Credit check, FIFO push/pop qualification; redirect and reset suppress all traffic.
  always_comb begin
    credit_used = {1'b0, count} + {{CNT_W{1'b0}}, outstanding};
    fifo_empty  = (count == {CNT_W{1'b0}});
    req         = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    if (rst || redirect_valid) begin
      req  = 1'b0;
      push = 1'b0;
      pop  = 1'b0;
    end else begin
      if (credit_used < DEPTH_C) begin
        req = 1'b1;
      end else begin
        req = 1'b0;
      end
      // An rvalid without a matching request is ignored.
      push = imem_rvalid && outstanding;
      pop  = !stall && !fifo_empty;
    end
  end

  assign imem_req  = req;
  assign imem_addr = pc;

  // PC, pointers, occupancy and outstanding-read tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc           <= RESET_PC;
      rd_ptr       <= {PTR_W{1'b0}};
      wr_ptr       <= {PTR_W{1'b0}};
      count        <= {CNT_W{1'b0}};
      outstanding  <= 1'b0;
      pending_addr <= {LS_ADDR_W{1'b0}};
    end else if (redirect_valid) begin
      // Latency is fixed at one, so the stale response lands in this very
      // cycle and is dropped simply by not pushing and clearing the flag.
      pc          <= redirect_pc & DW_MASK;
      rd_ptr      <= {PTR_W{1'b0}};
      wr_ptr      <= {PTR_W{1'b0}};
      count       <= {CNT_W{1'b0}};
      outstanding <= 1'b0;
    end else begin
      outstanding <= req;
      if (req) begin
        pc           <= pc + PC_STEP;
        pending_addr <= pc;
      end
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= imem_rdata;
      fifo_addr[wr_ptr] <= pending_addr;
    end
  end

  // Decode-facing output register: head pair, filler pair, or hold under stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      instruction_in1 <= NOP_WORD;
      instruction_in2 <= LNOP_WORD;
      instr_valid     <= 1'b0;
      fetch_pc        <= {LS_ADDR_W{1'b0}};
    end else if (redirect_valid) begin
      instruction_in1 <= NOP_WORD;
      instruction_in2 <= LNOP_WORD;
      instr_valid     <= 1'b0;
    end else if (pop) begin
      instruction_in1 <= fifo_data[rd_ptr][0:31];
      instruction_in2 <= fifo_data[rd_ptr][32:63];
      instr_valid     <= 1'b1;
      fetch_pc        <= fifo_addr[rd_ptr];
    end else if (!stall) begin
      instruction_in1 <= NOP_WORD;
      instruction_in2 <= LNOP_WORD;
      instr_valid     <= 1'b0;
    end
  end

`ifdef FETCH_PERF_EN
  localparam logic [0:31] PERF_MAX = 32'hFFFF_FFFF;

  // Saturating bubble and stall counters, cleared by reset only.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_bubble_cnt <= 32'd0;
      perf_stall_cnt  <= 32'd0;
    end else begin
      if (!stall && fifo_empty && (perf_bubble_cnt != PERF_MAX)) begin
        perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
      end
      if (stall && (perf_stall_cnt != PERF_MAX)) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Self-checking bench for instr_fetch_buffer: queue-based fetch model, directed scenarios, then random traffic.
module tb_instr_fetch_buffer;

  localparam int DEPTH = 4;
  localparam logic [31:0] NOP  = 32'h4020_0000;
  localparam logic [31:0] LNOP = 32'h0020_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [17:0] redirect_pc = 18'd0;
  logic        imem_req;
  logic [17:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [0:63] imem_rdata = 64'd0;
  logic [0:31] instruction_in1;
  logic [0:31] instruction_in2;
  logic        instr_valid;
  logic [17:0] fetch_pc;

  instr_fetch_buffer #(.DEPTH(DEPTH), .LS_ADDR_W(18), .RESET_PC(18'h00000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instruction_in1(instruction_in1), .instruction_in2(instruction_in2),
    .instr_valid(instr_valid), .fetch_pc(fetch_pc)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Memory side: answers the request seen last cycle
  logic        mem_pend = 1'b0;
  logic [17:0] mem_addr = 18'd0;

  // Reference model state
  logic [17:0] m_pc = 18'd0;
  logic [17:0] m_q[$];
  logic        m_os = 1'b0;
  logic [17:0] m_os_addr = 18'd0;
  logic        m_valid = 1'b0;
  logic [31:0] m_in1 = NOP;
  logic [31:0] m_in2 = LNOP;
  logic [17:0] m_fpc = 18'd0;
  bit          ready = 1'b0;

  // Samples taken each step
  logic        s_req;
  logic [17:0] s_addr;
  logic        s_valid;
  logic [31:0] s_in1, s_in2;
  logic [17:0] s_fpc;

  int          nreq;
  logic [17:0] last_req_addr;

  function automatic logic [31:0] word(input logic [17:0] a);
    return {8'hC3, 6'd0, a};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic st, input logic rv, input logic [17:0] rpc, input logic spur);
    logic        exp_req;
    logic [17:0] a;
    @(negedge clk);
    rst = r; stall = st; redirect_valid = rv; redirect_pc = rpc;
    if (mem_pend) begin
      imem_rvalid = 1'b1;
      imem_rdata  = {word(mem_addr), word(mem_addr + 18'd4)};
    end else if (spur) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 64'hDEAD_BEEF_0BAD_F00D;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 64'd0;
    end
    #1;
    s_req = imem_req; s_addr = imem_addr; s_valid = instr_valid;
    s_in1 = instruction_in1; s_in2 = instruction_in2; s_fpc = fetch_pc;
    mem_pend = imem_req;
    mem_addr = imem_addr;

    exp_req = !r && !rv && ((m_q.size() + int'(m_os)) < DEPTH);
    if (ready) begin
      chk("imem_req", s_req, exp_req);
      if (exp_req) chk("imem_addr", s_addr, m_pc);
      chk("instr_valid", s_valid, m_valid);
      chk("instruction_in1", s_in1, m_in1);
      chk("instruction_in2", s_in2, m_in2);
      if (m_valid) chk("fetch_pc", s_fpc, m_fpc);
    end

    if (r) begin
      m_pc = 18'd0; m_q.delete(); m_os = 1'b0;
      m_valid = 1'b0; m_in1 = NOP; m_in2 = LNOP; m_fpc = 18'd0;
      ready = 1'b1;
    end else if (rv) begin
      m_q.delete(); m_os = 1'b0;
      m_valid = 1'b0; m_in1 = NOP; m_in2 = LNOP;
      m_pc = rpc & 18'h3FFF8;
    end else begin
      // Pop sees the FIFO as it was before this cycle's push
      if (!st) begin
        if (m_q.size() > 0) begin
          a = m_q.pop_front();
          m_valid = 1'b1; m_in1 = word(a); m_in2 = word(a + 18'd4); m_fpc = a;
        end else begin
          m_valid = 1'b0; m_in1 = NOP; m_in2 = LNOP;
        end
      end
      if (imem_rvalid && m_os) m_q.push_back(m_os_addr);
      m_os = exp_req;
      if (exp_req) begin
        m_os_addr = m_pc;
        m_pc = m_pc + 18'd8;
      end
    end
  endtask

  initial begin
    logic        r, st, rv, sp;
    logic [17:0] rpc;

    step(1'b1, 1'b0, 1'b0, 18'd0, 1'b0);
    chk("rst_req", s_req, 1'b0);
    step(1'b1, 1'b0, 1'b0, 18'd0, 1'b0);

    // Free run from reset
    step(1'b0, 1'b0, 1'b0, 18'd0, 1'b0);
    chk("reset_valid", s_valid, 1'b0);
    chk("reset_in1", s_in1, 32'h4020_0000);
    chk("reset_in2", s_in2, 32'h0020_0000);
    chk("reset_fetch_pc", s_fpc, 18'h00000);
    chk("c0_req", s_req, 1'b1);
    chk("c0_addr", s_addr, 18'h00000);
    step(1'b0, 1'b0, 1'b0, 18'd0, 1'b0);
    chk("c1_addr", s_addr, 18'h00008);
    step(1'b0, 1'b0, 1'b0, 18'd0, 1'b0);
    chk("c2_addr", s_addr, 18'h00010);
    chk("c2_valid", s_valid, 1'b0);
    step(1'b0, 1'b0, 1'b0, 18'd0, 1'b0);
    chk("c3_valid", s_valid, 1'b1);
    chk("c3_in1", s_in1, 32'hC300_0000);
    chk("c3_in2", s_in2, 32'hC300_0004);
    chk("c3_fetch_pc", s_fpc, 18'h00000);
    step(1'b0, 1'b0, 1'b0, 18'd0, 1'b0);
    chk("c4_fetch_pc", s_fpc, 18'h00008);
    step(1'b0, 1'b0, 1'b0, 18'd0, 1'b0);
    chk("c5_fetch_pc", s_fpc, 18'h00010);

    // Stall for 10 cycles: credits run out, outputs frozen on the pair at 24
    nreq = 0;
    last_req_addr = 18'd0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 1'b0, 18'd0, 1'b0);
      if (s_req) begin
        nreq++;
        last_req_addr = s_addr;
      end
    end
    chk("stall_req_count", nreq, 2);
    chk("stall_last_req_addr", last_req_addr, 18'h00038);
    chk("stall_req_off", s_req, 1'b0);
    chk("stall_frozen_pc", s_fpc, 18'h00018);
    chk("stall_frozen_in1", s_in1, 32'hC300_0018);
    step(1'b0, 1'b0, 1'b0, 18'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 18'd0, 1'b0);
    chk("resume_fetch_pc", s_fpc, 18'h00020);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 18'd0, 1'b0);

    // Redirect while a read is outstanding
    step(1'b0, 1'b0, 1'b1, 18'h00104, 1'b0);
    chk("redir_had_rvalid", imem_rvalid, 1'b1);
    step(1'b0, 1'b0, 1'b0, 18'd0, 1'b0);
    chk("redir_req", s_req, 1'b1);
    chk("redir_addr", s_addr, 18'h00100);
    chk("redir_valid0", s_valid, 1'b0);
    step(1'b0, 1'b0, 1'b0, 18'd0, 1'b0);
    chk("redir_valid1", s_valid, 1'b0);
    step(1'b0, 1'b0, 1'b0, 18'd0, 1'b0);
    chk("redir_valid2", s_valid, 1'b0);
    step(1'b0, 1'b0, 1'b0, 18'd0, 1'b0);
    chk("redir_first_valid", s_valid, 1'b1);
    chk("redir_first_pc", s_fpc, 18'h00100);
    chk("redir_first_in1", s_in1, 32'hC300_0100);

    // Fill the FIFO under stall, then redirect with stall still high
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 18'd0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 18'h00200, 1'b0);
    step(1'b0, 1'b1, 1'b0, 18'd0, 1'b0);
    chk("rs_valid", s_valid, 1'b0);
    chk("rs_in1", s_in1, 32'h4020_0000);
    chk("rs_in2", s_in2, 32'h0020_0000);
    chk("rs_addr", s_addr, 18'h00200);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 18'd0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 18'd0, 1'b0);

    // PC wrap at the top of local store
    step(1'b0, 1'b0, 1'b1, 18'h3FFF8, 1'b0);
    step(1'b0, 1'b0, 1'b0, 18'd0, 1'b0);
    chk("wrap_addr0", s_addr, 18'h3FFF8);
    step(1'b0, 1'b0, 1'b0, 18'd0, 1'b0);
    chk("wrap_addr1", s_addr, 18'h00000);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 18'd0, 1'b0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 199) == 0);
      rv = ($urandom_range(0, 19) == 0);
      st = ($urandom_range(0, 2) == 0);
      sp = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0) rpc = 18'h3FFF0 + 18'($urandom_range(0, 15));
      else rpc = 18'($urandom());
      step(r, st, rv, rpc, sp);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
